// File: rtl/spi_seq_pkg.sv
// -----------------------------------------------------------------------------
// spi_seq_pkg
// Shared types and constants for the SPI command sequencer:
//   state_t           sequencer FSM states
//   CMD_WR_BIT        cmd byte bit selecting write (1) or read (0)
//   CMD_ADDR_MSB      top bit of the start address field in the cmd byte
//   ERR_BYTE_DEFAULT  MISO filler for frames addressing a missing register
//   next_ptr()        auto-increment of the register pointer, wrapping at nreg
// -----------------------------------------------------------------------------
package spi_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CMD   = 2'd1,
      DATA  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam int         CMD_WR_BIT       = 7;
   localparam int         CMD_ADDR_MSB     = 3;
   localparam logic [7:0] ERR_BYTE_DEFAULT = 8'hEE;

   function automatic logic [3:0] next_ptr(input logic [3:0] p, input int nreg);
      return (int'(p) == nreg - 1) ? 4'd0 : p + 4'd1;
   endfunction

endpackage

// File: rtl/spi_reg_bank.sv
// -----------------------------------------------------------------------------
// spi_reg_bank
// NREG x 8-bit register file. Registers 0 and 1 are read-only views of the
// input snapshot; registers 2..NREG-1 are writable through a single port.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   we         write enable (already arbitrated by the sequencer)
//   waddr      write address; 0, 1 and >= NREG are silently dropped
//   wdata      write data
//   snap       12-bit input snapshot (reg0 = snap[7:0], reg1 = snap[11:8])
//   raddr      combinational read address; >= NREG reads as 0
//   rdata      combinational read data
//   cfg_regs   registers 2..NREG-1 flattened, reg2 in [7:0]
// -----------------------------------------------------------------------------
module spi_reg_bank
   import spi_seq_pkg::*;
#(
   parameter int NREG = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [3:0]            waddr,
   input  logic [7:0]            wdata,
   input  logic [11:0]           snap,
   input  logic [3:0]            raddr,
   output logic [7:0]            rdata,
   output logic [8*(NREG-2)-1:0] cfg_regs
);

   logic [7:0] rw_q [2:NREG-1];

   // NOTE: this is a handful of flops, not a RAM macro, so it is cleared on
   // reset like any other state; a real memory array would be left unreset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 2; i < NREG; i++) rw_q[i] <= '0;
      end else if (we) begin
         // Only storage-backed addresses match, so the read-only and
         // out-of-range addresses fall through without effect.
         for (int i = 2; i < NREG; i++) begin
            if (waddr == 4'(i)) rw_q[i] <= wdata;
         end
      end
   end

   // NOTE: every combinational output gets a default before any branch so
   // no path leaves it unassigned (which would infer a latch).
   always_comb begin
      rdata = '0;
      if (raddr == 4'd0) rdata = snap[7:0];
      else if (raddr == 4'd1) rdata = {4'b0, snap[11:8]};
      for (int i = 2; i < NREG; i++) begin
         if (raddr == 4'(i)) rdata = rw_q[i];
      end
   end

   for (genvar g = 2; g < NREG; g++) begin : g_cfg
      assign cfg_regs[8*(g-2) +: 8] = rw_q[g];
   end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// spi_cmd_sequencer
// Command/register controller behind a byte-level SPI slave core. Decodes the
// cmd byte of each frame, then walks an auto-incrementing pointer through the
// register bank for reads or writes, and selects the next MISO byte. A local
// write port shares the bank; SPI writes win collisions.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   frame_start   1-cycle pulse, SSEL falling edge
//   frame_end     1-cycle pulse, SSEL rising edge
//   rx_valid      1-cycle pulse, rx_byte holds a received byte
//   rx_byte       received byte
//   tx_byte       byte the core loads at the next byte boundary
//   din           raw inputs, snapshotted at frame start
//   local_we      local write request, held until local_ack
//   local_addr    local write address
//   local_wdata   local write data
//   local_ack     1-cycle pulse, local write committed
//   cfg_regs      registers 2..NREG-1 flattened, reg2 in [7:0]
//   led           reg2[0]
//   frame_cnt     frames started since reset (wraps)
//   busy          sequencer not idle
//   cmd_err       1-cycle pulse, cmd address >= NREG
// -----------------------------------------------------------------------------
module spi_cmd_sequencer
   import spi_seq_pkg::*;
#(
   parameter int         NREG     = 8,
   parameter logic [7:0] ERR_BYTE = ERR_BYTE_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  frame_start,
   input  logic                  frame_end,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_byte,
   output logic [7:0]            tx_byte,
   input  logic [11:0]           din,
   input  logic                  local_we,
   input  logic [3:0]            local_addr,
   input  logic [7:0]            local_wdata,
   output logic                  local_ack,
   output logic [8*(NREG-2)-1:0] cfg_regs,
   output logic                  led,
   output logic [7:0]            frame_cnt,
   output logic                  busy,
   output logic                  cmd_err
);

   state_t      state_q, state_d;
   logic [11:0] snap_q;
   logic [3:0]  ptr_q;
   logic        wr_q;

   logic [3:0]  cmd_addr;
   logic        addr_ok;
   logic [3:0]  ptr_nxt;
   logic        take_byte;
   logic        spi_we;
   logic        local_commit;
   logic        bank_we;
   logic [3:0]  bank_waddr;
   logic [7:0]  bank_wdata;
   logic [3:0]  bank_raddr;
   logic [7:0]  bank_rdata;

   // ---------------------------------------------------------------- FSM state
   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // pre-edge values, independent of the order of statements.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // ------------------------------------------ next state and control strobes
   always_comb begin
      state_d    = state_q;
      cmd_addr   = rx_byte[CMD_ADDR_MSB:0];
      addr_ok    = int'(cmd_addr) < NREG;
      ptr_nxt    = next_ptr(ptr_q, NREG);
      // A frame boundary in the same cycle supersedes the byte.
      take_byte  = rx_valid && !frame_start && !frame_end;

      // Any SPI write cycle blocks the local port, even one that the bank
      // will drop because it targets a read-only register.
      spi_we       = take_byte && (state_q == DATA) && wr_q;
      // The ack is still high the cycle after commit while the requester
      // drops local_we, so that cycle must not commit the write again.
      local_commit = local_we && !local_ack && !spi_we;

      bank_we    = spi_we || local_commit;
      bank_waddr = spi_we ? ptr_q   : local_addr;
      bank_wdata = spi_we ? rx_byte : local_wdata;
      bank_raddr = (state_q == CMD) ? cmd_addr : ptr_nxt;

      if (frame_start) begin
         state_d = CMD;
      end else if (frame_end) begin
         state_d = IDLE;
      end else if (rx_valid && state_q == CMD) begin
         state_d = addr_ok ? DATA : DRAIN;
      end
   end

   // ------------------------------------------------------------------ datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         snap_q    <= '0;
         ptr_q     <= '0;
         wr_q      <= 1'b0;
         tx_byte   <= '0;
         frame_cnt <= '0;
         local_ack <= 1'b0;
         cmd_err   <= 1'b0;
      end else begin
         local_ack <= local_commit;
         cmd_err   <= 1'b0;
         if (frame_start) begin
            snap_q    <= din;
            frame_cnt <= frame_cnt + 8'd1;
            tx_byte   <= frame_cnt;
         end else if (take_byte) begin
            case (state_q)
               CMD: begin
                  ptr_q <= cmd_addr;
                  wr_q  <= rx_byte[CMD_WR_BIT];
                  if (addr_ok) begin
                     tx_byte <= bank_rdata;
                  end else begin
                     tx_byte <= ERR_BYTE;
                     cmd_err <= 1'b1;
                  end
               end
               DATA: begin
                  // bank_rdata is the pre-write value of the next register.
                  ptr_q   <= ptr_nxt;
                  tx_byte <= bank_rdata;
               end
               DRAIN:   tx_byte <= ERR_BYTE;
               default: ;
            endcase
         end
      end
   end

   spi_reg_bank #(
      .NREG(NREG)
   ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .we      (bank_we),
      .waddr   (bank_waddr),
      .wdata   (bank_wdata),
      .snap    (snap_q),
      .raddr   (bank_raddr),
      .rdata   (bank_rdata),
      .cfg_regs(cfg_regs)
   );

   assign led  = cfg_regs[0];
   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_spi_cmd_sequencer
// Scoreboarded bench: every frame_start / rx_valid pushes the MISO byte and
// cmd_err value a frame-level reference model predicts; a monitor pops one
// entry per such event and compares it with the DUT one clock later.
// -----------------------------------------------------------------------------
module tb_spi_cmd_sequencer;

   localparam int         NREG = 8;
   localparam logic [7:0] ERRB = 8'hEE;
   localparam int         GAP  = 2;

   logic                  clk;
   logic                  rst;
   logic                  frame_start;
   logic                  frame_end;
   logic                  rx_valid;
   logic [7:0]            rx_byte;
   logic [7:0]            tx_byte;
   logic [11:0]           din;
   logic                  local_we;
   logic [3:0]            local_addr;
   logic [7:0]            local_wdata;
   logic                  local_ack;
   logic [8*(NREG-2)-1:0] cfg_regs;
   logic                  led;
   logic [7:0]            frame_cnt;
   logic                  busy;
   logic                  cmd_err;

   spi_cmd_sequencer #(
      .NREG    (NREG),
      .ERR_BYTE(ERRB)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .frame_start(frame_start),
      .frame_end  (frame_end),
      .rx_valid   (rx_valid),
      .rx_byte    (rx_byte),
      .tx_byte    (tx_byte),
      .din        (din),
      .local_we   (local_we),
      .local_addr (local_addr),
      .local_wdata(local_wdata),
      .local_ack  (local_ack),
      .cfg_regs   (cfg_regs),
      .led        (led),
      .frame_cnt  (frame_cnt),
      .busy       (busy),
      .cmd_err    (cmd_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------ scoreboard
   typedef struct {
      logic [7:0] tx;
      logic       err;
      string      tag;
   } exp_t;

   exp_t exp_q[$];

   task automatic push_exp(input logic [7:0] tx, input logic err, input string tag);
      exp_t e;
      e.tx  = tx;
      e.err = err;
      e.tag = tag;
      exp_q.push_back(e);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         if (!rst && (frame_start || rx_valid)) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_underflow: DUT event with no expected entry (t=%0t)", $time);
            end else begin
               e = exp_q.pop_front();
               check({e.tag, "_tx"}, tx_byte, e.tx);
               check({e.tag, "_cmd_err"}, cmd_err, e.err);
            end
         end
      end
   end

   // ------------------------------------------------------- reference model
   // Frame-level view: phase 0 = no frame, 1 = awaiting cmd, 2 = register
   // transfer, 3 = bad command (filler only).
   logic [7:0] m_regs [16];
   logic [7:0] m_cnt;
   logic [7:0] m_tx;
   int         m_phase;
   int         m_ptr;
   bit         m_wr;

   function automatic void model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_cnt   = '0;
      m_tx    = '0;
      m_phase = 0;
      m_ptr   = 0;
      m_wr    = 1'b0;
   endfunction

   function automatic void model_start(input logic [11:0] d);
      m_regs[0] = d[7:0];
      m_regs[1] = {4'b0, d[11:8]};
      m_tx      = m_cnt;
      m_cnt     = m_cnt + 8'd1;
      m_phase   = 1;
   endfunction

   function automatic void model_byte(input logic [7:0] b, output logic err);
      int a;
      int nxt;
      err = 1'b0;
      case (m_phase)
         1: begin
            a = int'(b[3:0]);
            if (a < NREG) begin
               m_ptr   = a;
               m_wr    = b[7];
               m_tx    = m_regs[a];
               m_phase = 2;
            end else begin
               m_tx    = ERRB;
               err     = 1'b1;
               m_phase = 3;
            end
         end
         2: begin
            nxt  = (m_ptr + 1) % NREG;
            m_tx = m_regs[nxt];
            if (m_wr && m_ptr >= 2) m_regs[m_ptr] = b;
            m_ptr = nxt;
         end
         3: m_tx = ERRB;
         default: ;
      endcase
   endfunction

   function automatic void model_local(input int a, input logic [7:0] d);
      if (a >= 2 && a < NREG) m_regs[a] = d;
   endfunction

   function automatic logic [63:0] m_cfg();
      logic [63:0] v;
      v = '0;
      for (int i = 2; i < NREG; i++) v[8*(i-2) +: 8] = m_regs[i];
      return v;
   endfunction

   // -------------------------------------------------------------- stimulus
   task automatic start_frame(input logic [11:0] d);
      @(posedge clk);
      #1;
      din         = d;
      frame_start = 1'b1;
      model_start(d);
      push_exp(m_tx, 1'b0, "fs");
      @(posedge clk);
      #1;
      frame_start = 1'b0;
      din         = 12'($urandom);
      repeat (GAP) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic err;
      @(posedge clk);
      #1;
      rx_valid = 1'b1;
      rx_byte  = b;
      model_byte(b, err);
      push_exp(m_tx, err, "byte");
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      rx_byte  = 8'($urandom);
      repeat (GAP) @(posedge clk);
      #1;
   endtask

   task automatic end_frame();
      @(posedge clk);
      #1;
      frame_end = 1'b1;
      m_phase   = 0;
      @(posedge clk);
      #1;
      frame_end = 1'b0;
      check("busy_after_end", busy, 1'b0);
      check("cfg_after_end", cfg_regs, m_cfg());
      check("frame_cnt_after_end", frame_cnt, m_cnt);
   endtask

   task automatic local_write(input logic [3:0] a, input logic [7:0] d, input int exp_lat);
      int n;
      @(posedge clk);
      #1;
      local_we    = 1'b1;
      local_addr  = a;
      local_wdata = d;
      n = 0;
      while (n < 10) begin
         @(negedge clk);
         n++;
         if (local_ack) break;
      end
      check("local_ack_latency", n, exp_lat);
      local_we = 1'b0;
      model_local(int'(a), d);
      @(negedge clk);
      check("local_ack_pulse", local_ack, 1'b0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst         = 1'b1;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      rx_valid    = 1'b0;
      rx_byte     = '0;
      din         = '0;
      local_we    = 1'b0;
      local_addr  = '0;
      local_wdata = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      check("rst_tx", tx_byte, 8'h00);
      check("rst_frame_cnt", frame_cnt, 8'h00);
      check("rst_busy", busy, 1'b0);
      check("rst_cfg", cfg_regs, 48'h0);
      check("rst_led", led, 1'b0);
      check("rst_local_ack", local_ack, 1'b0);
      check("rst_cmd_err", cmd_err, 1'b0);

      // Snapshot read frame
      start_frame(12'hA5C);
      check("read_tx_fs", tx_byte, 8'h00);
      send_byte(8'h00);
      check("read_tx_reg0", tx_byte, 8'h5C);
      send_byte(8'h3C);
      check("read_tx_reg1", tx_byte, 8'h0A);
      end_frame();
      check("read_frame_cnt", frame_cnt, 8'd1);

      // Write frame
      start_frame(12'($urandom));
      send_byte(8'h82);
      check("write_tx_old_reg2", tx_byte, 8'h00);
      send_byte(8'h11);
      send_byte(8'h22);
      end_frame();
      check("write_reg2", cfg_regs[7:0], 8'h11);
      check("write_reg3", cfg_regs[15:8], 8'h22);
      check("write_led", led, 1'b1);

      // Wrap from reg7 through the read-only registers, then all the way
      // round so the last byte reads reg0 back.
      start_frame(12'h3C7);
      send_byte(8'h87);
      send_byte(8'h33);
      send_byte(8'h44);
      check("wrap_reg7", cfg_regs[47:40], 8'h33);
      check("wrap_tx_reg1", tx_byte, 8'h03);
      for (int i = 0; i < 6; i++) send_byte(8'($urandom));
      send_byte(8'h5A);
      check("wrap_reg0_ro", tx_byte, 8'hC7);
      end_frame();

      // Bad address
      start_frame(12'($urandom));
      send_byte(8'h0C);
      check("bad_cmd_err_pulse", cmd_err, 1'b0);
      check("bad_tx", tx_byte, ERRB);
      for (int i = 0; i < 3; i++) send_byte(8'($urandom));
      end_frame();

      // Collision: local write to reg3 in the same cycle as an SPI write
      start_frame(12'($urandom));
      send_byte(8'h82);
      fork
         send_byte(8'h55);
         local_write(4'd3, 8'h99, 3);
      join
      end_frame();
      check("coll_reg2", cfg_regs[7:0], 8'h55);
      check("coll_reg3", cfg_regs[15:8], 8'h99);

      // Abort by a fresh frame_start after the cmd byte
      start_frame(12'($urandom));
      send_byte(8'h02);
      start_frame(12'($urandom));
      check("abort_busy", busy, 1'b1);
      check("abort_frame_cnt", frame_cnt, m_cnt);
      send_byte(8'h03);
      send_byte(8'h00);
      end_frame();

      // Reset in the middle of a write frame
      start_frame(12'($urandom));
      send_byte(8'h82);
      send_byte(8'h77);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      check("midrst_cfg", cfg_regs, 48'h0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_frame_cnt", frame_cnt, 8'h00);
      send_byte(8'h12);
      check("midrst_ignored", cfg_regs, 48'h0);

      // Randomized frames with local writes and stray bytes between them
      for (int f = 0; f < 40; f++) begin
         int nbytes;
         logic [7:0] cmd;
         if ($urandom_range(0, 3) == 0) send_byte(8'($urandom));
         if ($urandom_range(0, 2) == 0)
            local_write(4'($urandom_range(0, 15)), 8'($urandom), 2);
         start_frame(12'($urandom));
         cmd = 8'($urandom);
         cmd[3:0] = 4'($urandom_range(0, 11));
         send_byte(cmd);
         nbytes = $urandom_range(0, 6);
         for (int i = 0; i < nbytes; i++) send_byte(8'($urandom));
         end_frame();
      end

      repeat (3) @(posedge clk);
      check("sb_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
